dbg_cmd_bridge: RTL and testbench



---
 rtl/dbg_cmd_pkg.sv | 23 ++
 rtl/dbg_cmd_fifo.sv | 51 +++++
 rtl/dbg_cmd_bridge.sv | 105 ++++++++++
 tb/tb_dbg_cmd_bridge.sv | 284 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dbg_cmd_pkg.sv
// Shared definitions for the system-clock side of the JTAG debug command path:
// IR codes, the default command entry layout and the FIFO level width helper.
package dbg_cmd_pkg;

    localparam logic [1:0] OCIMEM    = 2'd0;
    localparam logic [1:0] TRACEMEM  = 2'd1;
    localparam logic [1:0] BREAK     = 2'd2;
    localparam logic [1:0] TRACECTRL = 2'd3;

    localparam int DEF_IR_W   = 2;
    localparam int DEF_DATA_W = 38;

    typedef struct packed {
        logic [DEF_IR_W-1:0]   ir;
        logic [DEF_DATA_W-1:0] data;
    } dbg_cmd_t;

    // Occupancy needs one bit more than the pointers so that "full" is representable.
    function automatic int level_w(input int depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/dbg_cmd_fifo.sv
// Synchronous first-word-fall-through FIFO; the head is read straight from storage
// and forced to zero while the FIFO is empty.
module dbg_cmd_fifo
    import dbg_cmd_pkg::*;
#(
    parameter int WIDTH = 40,
    parameter int DEPTH = 4
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      push,
    input  logic [WIDTH-1:0]          din,
    input  logic                      pop,
    output logic [WIDTH-1:0]          dout,
    output logic                      full,
    output logic                      empty,
    output logic [level_w(DEPTH)-1:0] level
);

    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [LW-1:0]    wr_cnt;
    logic [LW-1:0]    rd_cnt;
    logic             do_pop;
    logic             do_push;

    assign level   = wr_cnt - rd_cnt;
    assign full    = (level == LW'(DEPTH));
    assign empty   = (level == '0);
    assign do_pop  = pop & ~empty;
    // A push into a full FIFO is accepted only when the head leaves in the same cycle.
    assign do_push = push & (~full | do_pop);
    assign dout    = empty ? '0 : mem[rd_cnt[AW-1:0]];

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_cnt <= '0;
            rd_cnt <= '0;
        end else begin
            if (do_push) wr_cnt <= wr_cnt + LW'(1);
            if (do_pop)  rd_cnt <= rd_cnt + LW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_cnt[AW-1:0]] <= din;
    end

endmodule

// File: rtl/dbg_cmd_bridge.sv
// System-clock side of the JTAG debug path: turns update-IR/update-DR toggles from
// the TCK domain into {IR, shift register} commands queued for the OCI/trace logic.
module dbg_cmd_bridge
    import dbg_cmd_pkg::*;
#(
    parameter int IR_W        = 2,
    parameter int DATA_W      = 38,
    parameter int ACT_BIT     = 37,
    parameter int FIFO_DEPTH  = 4,
    parameter int SYNC_STAGES = 2
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic                           uir_tgl,
    input  logic                           udr_tgl,
    input  logic [IR_W-1:0]                ir_in,
    input  logic [DATA_W-1:0]              sr,
    output logic                           cmd_valid,
    input  logic                           cmd_ready,
    output logic [IR_W-1:0]                cmd_ir,
    output logic [DATA_W-1:0]              cmd_data,
    output logic                           cmd_action,
    output logic [level_w(FIFO_DEPTH)-1:0] fifo_level,
    output logic                           ovf,
    input  logic                           ovf_clr
);

    localparam int ENT_W = IR_W + DATA_W;
    localparam int ARM_N = SYNC_STAGES + 1;
    localparam int ARM_W = $clog2(ARM_N + 1);

    logic [SYNC_STAGES-1:0] uir_sync, udr_sync;
    logic                   uir_prev, udr_prev;
    logic                   uir_evt, udr_evt;
    logic [ARM_W-1:0]       arm_cnt;
    logic                   armed;
    logic [IR_W-1:0]        ir_lat;
    logic [IR_W-1:0]        push_ir;
    logic [ENT_W-1:0]       head;
    logic                   fifo_full, fifo_empty, pop;

    assign armed = (arm_cnt == ARM_W'(ARM_N));

    // Until armed, prev keeps following the synchronised level, so whatever the toggle
    // lines held across reset is absorbed instead of being seen as an event.
    always_ff @(posedge clk) begin
        if (reset) begin
            uir_sync <= '0;
            udr_sync <= '0;
            uir_prev <= 1'b0;
            udr_prev <= 1'b0;
            uir_evt  <= 1'b0;
            udr_evt  <= 1'b0;
            arm_cnt  <= '0;
            ir_lat   <= '0;
        end else begin
            uir_sync <= {uir_sync[SYNC_STAGES-2:0], uir_tgl};
            udr_sync <= {udr_sync[SYNC_STAGES-2:0], udr_tgl};
            uir_prev <= uir_sync[SYNC_STAGES-1];
            udr_prev <= udr_sync[SYNC_STAGES-1];
            uir_evt  <= armed & (uir_sync[SYNC_STAGES-1] ^ uir_prev);
            udr_evt  <= armed & (udr_sync[SYNC_STAGES-1] ^ udr_prev);
            if (!armed)  arm_cnt <= arm_cnt + ARM_W'(1);
            if (uir_evt) ir_lat  <= ir_in;
        end
    end

    // An update-IR landing with an update-DR means the DR scan belongs to the new IR.
    assign push_ir = uir_evt ? ir_in : ir_lat;

    // Handshake: the head transfers on a cycle with cmd_valid && cmd_ready; while valid is
    // high without ready, valid and the head fields hold steady.
    assign pop = cmd_valid & cmd_ready;

    dbg_cmd_fifo #(
        .WIDTH (ENT_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (udr_evt),
        .din   ({push_ir, sr}),
        .pop   (pop),
        .dout  (head),
        .full  (fifo_full),
        .empty (fifo_empty),
        .level (fifo_level)
    );

    assign cmd_valid  = ~fifo_empty;
    assign cmd_ir     = head[ENT_W-1:DATA_W];
    assign cmd_data   = head[DATA_W-1:0];
    assign cmd_action = cmd_data[ACT_BIT];

    always_ff @(posedge clk) begin
        if (reset) begin
            ovf <= 1'b0;
        end else if (udr_evt && fifo_full && !pop) begin
            ovf <= 1'b1;
        end else if (ovf_clr) begin
            ovf <= 1'b0;
        end
    end

endmodule

// File: tb/tb_dbg_cmd_bridge.sv
// Bench for dbg_cmd_bridge: directed scenarios plus random toggle traffic, checked
// every cycle against a queue-based model of the command stream.
module tb_dbg_cmd_bridge;
    import dbg_cmd_pkg::*;

    localparam int IR_W    = 2;
    localparam int DATA_W  = 38;
    localparam int ACT_BIT = 37;
    localparam int DEPTH   = 4;
    localparam int SS      = 2;
    localparam int LAT     = SS + 2;

    logic                   clk = 1'b0;
    logic                   reset = 1'b1;
    logic                   uir_tgl = 1'b0;
    logic                   udr_tgl = 1'b1;
    logic [IR_W-1:0]        ir_in = '0;
    logic [DATA_W-1:0]      sr = '0;
    logic                   cmd_valid;
    logic                   cmd_ready = 1'b0;
    logic [IR_W-1:0]        cmd_ir;
    logic [DATA_W-1:0]      cmd_data;
    logic                   cmd_action;
    logic [$clog2(DEPTH):0] fifo_level;
    logic                   ovf;
    logic                   ovf_clr = 1'b0;

    dbg_cmd_bridge #(
        .IR_W        (IR_W),
        .DATA_W      (DATA_W),
        .ACT_BIT     (ACT_BIT),
        .FIFO_DEPTH  (DEPTH),
        .SYNC_STAGES (SS)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .uir_tgl    (uir_tgl),
        .udr_tgl    (udr_tgl),
        .ir_in      (ir_in),
        .sr         (sr),
        .cmd_valid  (cmd_valid),
        .cmd_ready  (cmd_ready),
        .cmd_ir     (cmd_ir),
        .cmd_data   (cmd_data),
        .cmd_action (cmd_action),
        .fifo_level (fifo_level),
        .ovf        (ovf),
        .ovf_clr    (ovf_clr)
    );

    always #5 clk = ~clk;

    typedef struct {
        int                edge_n;
        int                k;
        bit                is_uir;
        logic [IR_W-1:0]   ir;
        logic [DATA_W-1:0] data;
    } ev_t;

    ev_t                      pend[$];
    logic [IR_W+DATA_W-1:0]   exp_q[$];
    int                       cyc = 0;
    int                       last_rst = 0;
    int                       n_chk = 0;
    int                       n_err = 0;
    logic                     ovf_m = 1'b0;
    logic [IR_W-1:0]          ir_lat_m = '0;
    bit                       rand_rdy = 1'b0;
    int                       rdy_pct = 50;
    logic [63:0]              r64;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%0h exp=%0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // Reference: a toggle driven in cycle k reaches the queue at edge k+LAT unless a reset
    // edge at or after k intervenes; update-IR lands before update-DR on the same edge.
    task automatic model_step();
        bit                push;
        bit                pop;
        logic [DATA_W-1:0] pd;
        ev_t               keep[$];
        cyc++;
        if (reset) begin
            exp_q.delete();
            ovf_m    = 1'b0;
            ir_lat_m = '0;
            last_rst = cyc;
        end else begin
            push = 1'b0;
            pd   = '0;
            pop  = (exp_q.size() != 0) && cmd_ready;
            foreach (pend[i])
                if (pend[i].edge_n == cyc && pend[i].k > last_rst && pend[i].is_uir)
                    ir_lat_m = pend[i].ir;
            foreach (pend[i])
                if (pend[i].edge_n == cyc && pend[i].k > last_rst && !pend[i].is_uir) begin
                    push = 1'b1;
                    pd   = pend[i].data;
                end
            if (pop) void'(exp_q.pop_front());
            if (push && exp_q.size() == DEPTH) ovf_m = 1'b1;
            else begin
                if (push) exp_q.push_back({ir_lat_m, pd});
                if (ovf_clr) ovf_m = 1'b0;
            end
        end
        foreach (pend[i]) if (pend[i].edge_n > cyc) keep.push_back(pend[i]);
        pend = keep;
    endtask

    task automatic compare();
        dbg_cmd_t h;
        check("valid", 64'(cmd_valid), 64'(exp_q.size() != 0));
        check("level", 64'(fifo_level), 64'(exp_q.size()));
        check("ovf", 64'(ovf), 64'(ovf_m));
        if (exp_q.size() != 0) begin
            h = exp_q[0];
            check("head_ir", 64'(cmd_ir), 64'(h.ir));
            check("head_data", 64'(cmd_data), 64'(h.data));
            check("head_action", 64'(cmd_action), 64'(h.data[ACT_BIT]));
        end
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        #1;
        compare();
        if (rand_rdy) cmd_ready = ($urandom_range(0, 99) < rdy_pct);
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic uir_cmd(input logic [IR_W-1:0] ir);
        ev_t e;
        ir_in   = ir;
        uir_tgl = ~uir_tgl;
        e.edge_n = cyc + LAT; e.k = cyc; e.is_uir = 1'b1; e.ir = ir; e.data = '0;
        pend.push_back(e);
    endtask

    task automatic udr_cmd(input logic [DATA_W-1:0] d, input bit with_uir, input logic [IR_W-1:0] ir);
        ev_t e;
        if (with_uir) uir_cmd(ir);
        sr      = d;
        udr_tgl = ~udr_tgl;
        e.edge_n = cyc + LAT; e.k = cyc; e.is_uir = 1'b0; e.ir = '0; e.data = d;
        pend.push_back(e);
    endtask

    initial begin
        // 1: udr_tgl held high through reset must not create a command
        ticks(3);
        check("rst_valid", 64'(cmd_valid), 64'd0);
        check("rst_ir", 64'(cmd_ir), 64'd0);
        check("rst_data", 64'(cmd_data), 64'd0);
        check("rst_action", 64'(cmd_action), 64'd0);
        check("rst_level", 64'(fifo_level), 64'd0);
        check("rst_ovf", 64'(ovf), 64'd0);
        reset = 1'b0;
        for (int i = 0; i < 20; i++) begin
            tick();
            check("t1_idle_valid", 64'(cmd_valid), 64'd0);
        end
        check("t1_ovf", 64'(ovf), 64'd0);

        // 2: single BREAK command, latency and one-cycle valid pulse
        uir_cmd(BREAK);
        ticks(LAT);
        cmd_ready = 1'b1;
        udr_cmd(38'h20_0000_0ABC, 1'b0, '0);
        ticks(LAT - 1);
        check("t2_early", 64'(cmd_valid), 64'd0);
        tick();
        check("t2_valid", 64'(cmd_valid), 64'd1);
        check("t2_ir", 64'(cmd_ir), 64'(BREAK));
        check("t2_data", 64'(cmd_data), 64'h20_0000_0ABC);
        check("t2_action", 64'(cmd_action), 64'd1);
        tick();
        check("t2_pulse", 64'(cmd_valid), 64'd0);

        // 3: five pushes into a four-entry FIFO, then drain in order
        cmd_ready = 1'b0;
        for (int i = 1; i <= 5; i++) begin
            udr_cmd(DATA_W'(i), 1'b0, '0);
            ticks(LAT);
        end
        check("t3_level", 64'(fifo_level), 64'd4);
        check("t3_ovf", 64'(ovf), 64'd1);
        cmd_ready = 1'b1;
        for (int i = 1; i <= 4; i++) begin
            check("t3_pop_data", 64'(cmd_data), 64'(i));
            tick();
        end
        check("t3_empty", 64'(fifo_level), 64'd0);
        cmd_ready = 1'b0;
        ovf_clr = 1'b1;
        tick();
        ovf_clr = 1'b0;
        check("t3_ovf_clr", 64'(ovf), 64'd0);

        // 4: push and pop on the same edge with the FIFO full
        for (int i = 0; i < 4; i++) begin
            udr_cmd(DATA_W'(16 + i), 1'b0, '0);
            ticks(LAT);
        end
        udr_cmd(38'h3F_1234_5678, 1'b0, '0);
        ticks(LAT - 1);
        cmd_ready = 1'b1;
        tick();
        cmd_ready = 1'b0;
        check("t4_level", 64'(fifo_level), 64'd4);
        check("t4_ovf", 64'(ovf), 64'd0);
        cmd_ready = 1'b1;
        ticks(3);
        check("t4_last_level", 64'(fifo_level), 64'd1);
        check("t4_last_data", 64'(cmd_data), 64'h3F_1234_5678);
        tick();
        check("t4_drained", 64'(fifo_level), 64'd0);

        // 5: update-IR and update-DR in the same cycle take the new IR
        uir_cmd(OCIMEM);
        ticks(LAT);
        cmd_ready = 1'b0;
        udr_cmd(38'h00_0000_0055, 1'b1, TRACECTRL);
        ticks(LAT);
        check("t5_valid", 64'(cmd_valid), 64'd1);
        check("t5_ir", 64'(cmd_ir), 64'(TRACECTRL));
        cmd_ready = 1'b1;
        tick();
        cmd_ready = 1'b0;

        // 6: reset flushes the queue; toggles in flight or in the arming window are lost
        for (int i = 0; i < 3; i++) begin
            udr_cmd(DATA_W'(32 + i), 1'b0, '0);
            ticks(LAT);
        end
        check("t6_level_before", 64'(fifo_level), 64'd3);
        reset = 1'b1;
        udr_cmd(38'h11, 1'b0, '0);
        tick();
        check("t6_valid", 64'(cmd_valid), 64'd0);
        check("t6_level", 64'(fifo_level), 64'd0);
        check("t6_ovf", 64'(ovf), 64'd0);
        reset = 1'b0;
        udr_cmd(38'h22, 1'b0, '0);
        ticks(LAT + 4);
        check("t6_no_entry", 64'(fifo_level), 64'd0);
        udr_cmd(38'h33, 1'b0, '0);
        ticks(LAT);
        check("t6_rearmed", 64'(cmd_data), 64'h33);

        // Random traffic: slow consumer first to reach full/overflow, then a faster one
        rand_rdy = 1'b1;
        for (int it = 0; it < 300; it++) begin
            int unsigned op;
            rdy_pct = (it < 150) ? 12 : 55;
            op  = $urandom_range(0, 9);
            r64 = {$urandom(), $urandom()};
            if (op < 6)      udr_cmd(r64[DATA_W-1:0], bit'($urandom_range(0, 1)), IR_W'($urandom_range(0, 3)));
            else if (op < 8) uir_cmd(IR_W'($urandom_range(0, 3)));
            if ($urandom_range(0, 15) == 0) ovf_clr = 1'b1;
            tick();
            ovf_clr = 1'b0;
            ticks(LAT - 1 + $urandom_range(0, 2));
        end
        rand_rdy  = 1'b0;
        cmd_ready = 1'b1;
        ticks(10);
        check("final_empty", 64'(fifo_level), 64'd0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
